// File: rtl/update_knn1_pkg.sv
// Shared constants and types for the update_knn1 multiplier sharing logic.
package update_knn1_pkg;

    localparam int KNN_MUL_A_W = 17;
    localparam int KNN_MUL_B_W = 15;
    localparam int KNN_MUL_P_W = 32;
    localparam int KNN_MUL_LAT = 2;

    localparam int KNN_NUM_REQ = 4;
    localparam int KNN_ID_W    = $clog2(KNN_NUM_REQ);

    typedef logic [KNN_ID_W-1:0] knn_req_id_t;

    // Requester index reached by stepping 'offset' places past 'ptr', wrapping at numReq.
    function automatic int knnRrIndex(input int ptr, input int offset, input int numReq);
        return (ptr + offset) % numReq;
    endfunction

endpackage

// File: rtl/update_knn1_mul_mdEe.sv
// Two-stage pipelined unsigned multiplier with a common clock enable.
// Data registers carry no reset; whoever uses the product qualifies it with its own valid.
module update_knn1_mul_mdEe
    import update_knn1_pkg::*;
#(
    parameter int A_W = KNN_MUL_A_W,
    parameter int B_W = KNN_MUL_B_W,
    parameter int P_W = KNN_MUL_P_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [A_W-1:0] din0,
    input  logic [B_W-1:0] din1,
    output logic [P_W-1:0] dout
);

    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [P_W-1:0] p_q;
    logic           advance;

    assign advance = ce && !rst;

    // Operand capture stage, frozen while stalled or held in reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_q <= din0;
            b_q <= din1;
        end
    end

    // Product stage: full-width unsigned multiply, no truncation.
    always_ff @(posedge clk) begin
        if (advance) begin
            p_q <= P_W'(a_q) * P_W'(b_q);
        end
    end

    assign dout = p_q;

endmodule

// File: rtl/update_knn1_rr_arb.sv
// Round-robin grant over NUM_REQ requesters; the pointer remembers the last winner
// and only moves when a grant is actually taken (enable high).
module update_knn1_rr_arb
    import update_knn1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    int              gntIdx;

    // Search upward from the requester after the pointer; the nearest valid one wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gntIdx      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_i[knnRrIndex(int'(ptr_q), k, NUM_REQ)]) begin
                gnt_valid_o = 1'b1;
                gntIdx      = knnRrIndex(int'(ptr_q), k, NUM_REQ);
            end
        end
        gnt_id_o = ID_W'(gntIdx);
    end

    // The pointer follows the winner only when the grant is consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && gnt_valid_o) begin
            ptr_d = gnt_id_o;
        end
    end

    // Pointer starts at the last requester so requester 0 wins first after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/update_knn1_mul_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters. Each accepted operand
// pair is tagged with its requester ID, which travels beside the product pipe.
module update_knn1_mul_arb
    import update_knn1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int A_W     = KNN_MUL_A_W,
    parameter int B_W     = KNN_MUL_B_W,
    parameter int P_W     = KNN_MUL_P_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_p,
    output logic                   busy
);

    logic            stall;
    logic            accept;
    logic            gntValid;
    logic [ID_W-1:0] gntId;
    logic [A_W-1:0]  dinA;
    logic [B_W-1:0]  dinB;

    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic [ID_W-1:0] id1_q, id1_d;
    logic [ID_W-1:0] id2_q, id2_d;

    // A product waiting on the output with nobody taking it freezes the whole pipe.
    assign stall  = v2_q && !res_ready;
    assign accept = gntValid && !stall && reset_n;

    update_knn1_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (!stall),
        .req_i       (req_valid),
        .gnt_valid_o (gntValid),
        .gnt_id_o    (gntId)
    );

    // Ready goes only to the winner, and never while stalled or in reset.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gntId] = 1'b1;
        end
    end

    // Operand mux selects the winner's pair; zero when nobody is asking.
    always_comb begin
        dinA = '0;
        dinB = '0;
        if (gntValid) begin
            dinA = req_a[int'(gntId)*A_W +: A_W];
            dinB = req_b[int'(gntId)*B_W +: B_W];
        end
    end

    update_knn1_mul_mdEe #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .clk  (clk),
        .rst  (!reset_n),
        .ce   (!stall),
        .din0 (dinA),
        .din1 (dinB),
        .dout (res_p)
    );

    // Tag pipe mirrors the multiplier stages; everything holds while stalled.
    always_comb begin
        v1_d  = v1_q;
        id1_d = id1_q;
        v2_d  = v2_q;
        id2_d = id2_q;
        if (!stall) begin
            v1_d  = accept;
            v2_d  = v1_q;
            id2_d = id1_q;
            if (accept) begin
                id1_d = gntId;
            end
        end
    end

    // Tag pipe registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            id1_q <= '0;
            id2_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            id1_q <= id1_d;
            id2_q <= id2_d;
        end
    end

    assign res_valid = v2_q;
    assign res_id    = id2_q;
    assign busy      = v1_q || v2_q;

endmodule
